// File: rtl/data_mem_unit.sv
// Data-memory stage for the 16-bit single-cycle MIPS datapath: slow word RAM
// with a programmable wait count that holds the CPU via stall until done.
module data_mem_unit #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state, next_state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_idx;
  logic [15:0]       lat_wdata;
  logic              lat_write;
  logic              lat_err;

  logic              req;
  logic              req_err;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] acc_idx;
  logic [15:0]       acc_wdata;
  logic              acc_write;
  logic              acc_err;
  logic              enter_done;
  logic              do_write;
  logic              do_read;
  logic              unused_bits;

  logic [15:0] mem [0:(1<<ADDR_W)-1];

  assign req         = mem_read | mem_write;
  assign req_err     = (addr[1:0] != 2'b00) | (mem_read & mem_write);
  assign idx         = addr[ADDR_W+1:2];
  // Upper address bits are deliberately ignored so accesses wrap modulo depth.
  assign unused_bits = ^addr[15:ADDR_W+2];

  // A zero-wait access reaches DONE straight from IDLE, so it must use the
  // live request; every other access uses the copy latched in IDLE.
  assign acc_idx    = (state == S_IDLE) ? idx                       : lat_idx;
  assign acc_wdata  = (state == S_IDLE) ? wdata                     : lat_wdata;
  assign acc_write  = (state == S_IDLE) ? (mem_write & ~mem_read)   : lat_write;
  assign acc_err    = (state == S_IDLE) ? req_err                   : lat_err;
  assign enter_done = (next_state == S_DONE) & (state != S_DONE) & ~reset;
  assign do_write   = enter_done & acc_write & ~acc_err;
  assign do_read    = enter_done & ~acc_write & ~acc_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_idx   <= '0;
      lat_wdata <= 16'h0000;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      rdata     <= 16'h0000;
    end else begin
      state <= next_state;
      if (state == S_IDLE && req) begin
        cnt       <= CNT_INIT;
        lat_idx   <= idx;
        lat_wdata <= wdata;
        lat_write <= mem_write & ~mem_read;
        lat_err   <= req_err;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (do_read)
        rdata <= mem[acc_idx];
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clock) begin
    if (do_write)
      mem[acc_idx] <= acc_wdata;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (req)
          next_state = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (cnt == 4'd0)
          next_state = S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    stall = req & (state != S_DONE) & ~reset;
    done  = (state == S_DONE) & ~reset;
    err   = (state == S_DONE) & ~reset & lat_err;
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: a WAIT_CYCLES=2 instance and a
// WAIT_CYCLES=0 instance driven from one vector table plus corner sequences.
module tb_data_mem_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        rd, wr;
  logic [15:0] addr, wdata;
  logic        sel;

  logic [15:0] rdata_a, rdata_b;
  logic        stall_a, stall_b, done_a, done_b, err_a, err_b;
  logic [15:0] rdata_m;
  logic        stall_m, done_m, err_m;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int last_done_cyc;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  data_mem_unit #(.ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
    .clock(clock), .reset(reset),
    .mem_read(rd & ~sel), .mem_write(wr & ~sel),
    .addr(addr), .wdata(wdata),
    .rdata(rdata_a), .stall(stall_a), .done(done_a), .err(err_a)
  );

  data_mem_unit #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
    .clock(clock), .reset(reset),
    .mem_read(rd & sel), .mem_write(wr & sel),
    .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .stall(stall_b), .done(done_b), .err(err_b)
  );

  assign rdata_m = sel ? rdata_b : rdata_a;
  assign stall_m = sel ? stall_b : stall_a;
  assign done_m  = sel ? done_b  : done_a;
  assign err_m   = sel ? err_b   : err_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // op: 0 = LW, 1 = SW, 2 = read+write conflict
  task automatic access(input string name, input int op, input logic [15:0] a,
                        input logic [15:0] d, input int stall_len,
                        input logic exp_err, input logic [15:0] exp_rdata);
    int n;
    @(negedge clock);
    check({name, ".done_idle"}, done_m, 1'b0);
    rd = (op == 0 || op == 2);
    wr = (op == 1 || op == 2);
    addr = a;
    wdata = d;
    #1;
    check({name, ".stall0"}, stall_m, 1'b1);
    n = 0;
    while (stall_m && n < 40) begin
      n++;
      @(negedge clock);
    end
    check({name, ".stall_len"}, n, stall_len);
    check({name, ".done"}, done_m, 1'b1);
    check({name, ".err"}, err_m, exp_err);
    check({name, ".rdata"}, rdata_m, exp_rdata);
    last_done_cyc = cyc;
    rd = 1'b0;
    wr = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        dut;
    int          op;
    logic [15:0] a;
    logic [15:0] d;
    logic        exp_err;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t v[15];

  initial begin
    int d1, d2;
    v[0]  = '{"sw_10",       1'b0, 1, 16'h0010, 16'h00AB, 1'b0, 16'h0000};
    v[1]  = '{"lw_10",       1'b0, 0, 16'h0010, 16'h0000, 1'b0, 16'h00AB};
    v[2]  = '{"lw_13_mis",   1'b0, 0, 16'h0013, 16'h0000, 1'b1, 16'h00AB};
    v[3]  = '{"lw_10_again", 1'b0, 0, 16'h0010, 16'h0000, 1'b0, 16'h00AB};
    v[4]  = '{"sw_20",       1'b0, 1, 16'h0020, 16'h2222, 1'b0, 16'h00AB};
    v[5]  = '{"rw_20_conf",  1'b0, 2, 16'h0020, 16'hFFFF, 1'b1, 16'h00AB};
    v[6]  = '{"lw_20",       1'b0, 0, 16'h0020, 16'h0000, 1'b0, 16'h2222};
    v[7]  = '{"sw_40",       1'b0, 1, 16'h0040, 16'h1111, 1'b0, 16'h2222};
    v[8]  = '{"sw_404_wrap", 1'b0, 1, 16'h0404, 16'h0099, 1'b0, 16'h2222};
    v[9]  = '{"lw_04",       1'b0, 0, 16'h0004, 16'h0000, 1'b0, 16'h0099};
    v[10] = '{"sw_06_mis",   1'b0, 1, 16'h0006, 16'hDEAD, 1'b1, 16'h0099};
    v[11] = '{"lw_04_again", 1'b0, 0, 16'h0004, 16'h0000, 1'b0, 16'h0099};
    v[12] = '{"b_sw_00",     1'b1, 1, 16'h0000, 16'h1234, 1'b0, 16'h0000};
    v[13] = '{"b_lw_00",     1'b1, 0, 16'h0000, 16'h0000, 1'b0, 16'h1234};
    v[14] = '{"b_lw_402_mis",1'b1, 0, 16'h0402, 16'h0000, 1'b1, 16'h1234};

    reset = 1'b1; rd = 1'b1; wr = 1'b0; addr = 16'h0010; wdata = 16'h0; sel = 1'b0;
    repeat (3) @(negedge clock);
    check("rst.stall_forced", stall_m, 1'b0);
    check("rst.done", done_m, 1'b0);
    check("rst.err", err_m, 1'b0);
    check("rst.rdata_a", rdata_a, 16'h0000);
    check("rst.rdata_b", rdata_b, 16'h0000);
    rd = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      sel = v[i].dut;
      access(v[i].name, v[i].op, v[i].a, v[i].d, v[i].dut ? 1 : 3,
             v[i].exp_err, v[i].exp_rdata);
    end
    sel = 1'b0;

    // Reset while the store is still in WAIT.
    @(negedge clock);
    wr = 1'b1; addr = 16'h0040; wdata = 16'h5555;
    @(negedge clock);
    check("rst_mid.stall_wait", stall_m, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_mid.stall_now", stall_m, 1'b0);
    check("rst_mid.done_now", done_m, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("rst_mid.no_done", done_m, 1'b0);
      check("rst_mid.no_stall", stall_m, 1'b0);
    end
    wr = 1'b0;
    reset = 1'b0;
    access("lw_40_after_rst", 0, 16'h0040, 16'h0, 3, 1'b0, 16'h1111);

    // Back-to-back store then load with no idle cycle.
    access("b2b_sw_04", 1, 16'h0004, 16'h0007, 3, 1'b0, 16'h1111);
    d1 = last_done_cyc;
    access("b2b_lw_04", 0, 16'h0004, 16'h0, 3, 1'b0, 16'h0007);
    d2 = last_done_cyc;
    check("b2b.done_spacing", d2 - d1, 4);
    @(negedge clock);
    check("b2b.done_one_cycle", done_m, 1'b0);
    check("b2b.rdata_hold", rdata_m, 16'h0007);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
